operand_capture: RTL and testbench
==================================

# operand_capture

Upstream operand stage for the 16-bit decoded XOR datapath. Debounces one raw pushbutton and loads the 4-bit switch value into operand A on the first press and operand B on the second. It presents both operands with a `valid` flag to the decoder/XOR stage. The block replaces the direct `SW[3:0]`/`SW[7:4]` operand split, so only four switches are needed and operands are entered one at a time.

## Interface
- `DEBOUNCE_CYCLES`, default 500000. Number of consecutive clock cycles the synchronized key must differ from its stable value before the stable value changes (10 ms at 50 MHz). Legal range is 2 to 2^CNT_W−1.
- `CNT_W`, default 19. Width of the debounce counter.

- `CLOCK_50`  in  1  system clock; all logic is on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `KEY_load`  in  1  raw pushbutton, asynchronous to the clock, active-low (0 = pressed).
- `SW`  in  4  operand value to capture.
- `a`  out  4  operand A register.
- `b`  out  4  operand B register.
- `valid`  out  1  high when A and B are both captured for the current pair.
- `sel`  out  2  capture state: 00 = expecting A, 01 = expecting B, 10 = full.

## Operation
- **Synchronizer:** two flops, `sync1` then `sync2`, on `KEY_load`. Both reset to 1.
- **Debouncer:** `key_stable` resets to 1 and the counter `cnt` resets to 0.
  - If `sync2 == key_stable`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES−1`, then `key_stable <= sync2` and `cnt <= 0`.
  - Else `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `key_stable`.
- **Press event:** `press` is combinational. It is 1 exactly when the debouncer is about to change `key_stable` from 1 to 0 on this edge.
  - A release (0→1) produces no event.
  - One physical press gives exactly one event.
- **FSM:** states EXP_A (`sel` 00), EXP_B (`sel` 01), FULL (`sel` 10). `sel` 11 is unused; if ever reached, the next edge goes to EXP_A.
  - EXP_A and `press`: `a <= SW`, go to EXP_B.
  - EXP_B and `press`: `b <= SW`, `valid <= 1`, go to FULL.
  - FULL and `press`: `a <= SW`, `valid <= 0`, go to EXP_B. `b` holds its old value until it is overwritten.
  - No `press`: all registers hold.
- `a`, `b`, `valid` and `sel` are all registered outputs. `SW` is sampled only on the press edge; `SW` changes at any other time have no effect.

## Timing
- **Reset:** while `resetn` = 0 at a rising edge, the following values are forced and remain on the outputs until the first press: `a` = 0, `b` = 0, `valid` = 0, `sel` = 00, `sync1` = `sync2` = `key_stable` = 1, `cnt` = 0.
- **Press latency:** take edge 0 as the first edge at which `sync1` samples `KEY_load` = 0, with the key then held low.
  - `sync2` is 0 after edge 1.
  - `cnt` counts on edges 2 to D (D = `DEBOUNCE_CYCLES`).
  - `key_stable` falls and the capture occurs at edge D+1.
  - The new `a`/`b`/`valid`/`sel` values are visible after edge D+1.
- **Release:** the release also needs D consecutive cycles before `key_stable` returns to 1. A new press is recognised only after the release is stable.
- **Bounce:** any return of `sync2` to `key_stable` during counting clears `cnt`. The D-cycle count restarts from zero.
- **Reset mid-operation:** reset mid-debounce or mid-sequence discards partial counts and operands, and the FSM returns to EXP_A.
- **Key held through reset release:** if the key is held low while `resetn` goes high, this counts as one press. It captures A at edge D+1 after `sync1` first samples 0 post-reset.
- **`valid` timing:** `valid` rises on the same edge that `b` loads. It falls on the same edge that a new `a` loads.

## Test plan
Run the bench with `DEBOUNCE_CYCLES` = 4, so D+1 = 5.

1. **Reset:** assert `resetn` = 0 for 3 cycles with `KEY_load` = 1 → `a` = 0, `b` = 0, `valid` = 0, `sel` = 00.
2. **First press:** `SW` = 4'h3, hold `KEY_load` low for 10 cycles → `a` = 3 and `sel` = 01 exactly 5 edges after the first low sample. `b` = 0, `valid` = 0, and there is no second capture while the key is held.
3. **Second press:** release the key for 10 cycles, `SW` = 4'hA, press for 10 cycles → `b` = A, `valid` = 1, `sel` = 10, and `a` stays 3.
4. **Bounce:** toggle `KEY_load` low/high every 2 cycles for 20 cycles, then hold high → no capture, and all outputs stay unchanged.
5. **Wrap from FULL:** from FULL with `SW` = 4'h7, apply a clean press → `a` = 7, `valid` = 0, `sel` = 01, and `b` still = A. A further press with `SW` = 4'hF gives `b` = F and `valid` = 1.
6. **Reset mid-debounce:** assert `resetn` = 0 at cnt = 2 during a press in EXP_B → all outputs return to their reset values. With the key still held at reset release, `a` captures `SW` 5 edges after the first post-reset low sample.

Source files
------------

// File: rtl/operand_capture.sv
// operand_capture
// ---------------------------------------------------------------------------
// Operand entry stage for the decoded XOR datapath. One raw pushbutton is
// synchronized and debounced. Each clean press latches the 4-bit switch value
// into operand A, then into operand B, and then wraps back to A. `valid` tells
// the downstream stage when a complete A/B pair is present.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive cycles a key change must persist (2..2^CNT_W-1)
//   CNT_W           : debounce counter width
//
// Ports
//   CLOCK_50 : in   system clock, rising edge
//   resetn   : in   synchronous active-low reset
//   KEY_load : in   raw pushbutton, asynchronous, 0 = pressed
//   SW       : in   [3:0] operand value, sampled only on a press edge
//   a        : out  [3:0] operand A register
//   b        : out  [3:0] operand B register
//   valid    : out  A and B both captured for the current pair
//   sel      : out  [1:0] 00 = expecting A, 01 = expecting B, 10 = full
// ---------------------------------------------------------------------------
module operand_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       KEY_load,
  input  logic [3:0] SW,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       valid,
  output logic [1:0] sel
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    EXP_A = 2'b00,
    EXP_B = 2'b01,
    FULL  = 2'b10
  } state_e;

  // -------------------------------------------------------------------------
  // Synchronizer and debouncer
  // -------------------------------------------------------------------------
  logic             sync1_q, sync2_q;
  logic             key_stable_q, key_stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;   // stable value changes on this edge
  logic             press;

  always_comb begin
    key_stable_d = key_stable_q;
    cnt_d        = cnt_q;
    flip         = 1'b0;
    if (sync2_q == key_stable_q) begin
      // Any return to the stable level (bounce) restarts the count.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      flip         = 1'b1;
      key_stable_d = sync2_q;
      cnt_d        = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Only the 1->0 transition of the debounced key is an event; releases are
  // consumed silently so one physical press yields exactly one capture.
  assign press = flip && key_stable_q;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      key_stable_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= KEY_load;
      sync2_q      <= sync1_q;
      key_stable_q <= key_stable_d;
      cnt_q        <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Capture FSM
  // -------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    case (state_q)
      EXP_A: if (press) begin
        a_d     = SW;
        state_d = EXP_B;
      end
      EXP_B: if (press) begin
        b_d     = SW;
        valid_d = 1'b1;
        state_d = FULL;
      end
      FULL: if (press) begin
        // Start a new pair; old B stays visible until overwritten.
        a_d     = SW;
        valid_d = 1'b0;
        state_d = EXP_B;
      end
      default: state_d = EXP_A;  // unused encoding 11 recovers to EXP_A
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= EXP_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = valid_q;
  assign sel   = state_q;

endmodule

// File: tb/tb_operand_capture.sv
module tb_operand_capture;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       KEY_load = 1'b1;
  logic [3:0] SW       = 4'h0;
  logic [3:0] a, b;
  logic       valid;
  logic [1:0] sel;

  int n_checks = 0;
  int n_fail   = 0;

  operand_capture #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .KEY_load (KEY_load),
    .SW       (SW),
    .a        (a),
    .b        (b),
    .valid    (valid),
    .sel      (sel)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       key;
    logic [3:0] sw;
    int         ncyc;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ev;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[0:31];
  int   nv = 0;

  task automatic add(input logic key, input logic [3:0] sw, input int ncyc,
                     input logic [3:0] ea, input logic [3:0] eb,
                     input logic ev, input logic [1:0] es);
    vecs[nv].key  = key;
    vecs[nv].sw   = sw;
    vecs[nv].ncyc = ncyc;
    vecs[nv].ea   = ea;
    vecs[nv].eb   = eb;
    vecs[nv].ev   = ev;
    vecs[nv].es   = es;
    nv++;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic ev, input logic [1:0] es);
    check({tag, ".a"},     {4'h0, a},     {4'h0, ea});
    check({tag, ".b"},     {4'h0, b},     {4'h0, eb});
    check({tag, ".valid"}, {7'h0, valid}, {7'h0, ev});
    check({tag, ".sel"},   {6'h0, sel},   {6'h0, es});
  endtask

  initial begin
    // Second press, bounce, wrap from FULL, then set up EXP_B for the reset case.
    add(1'b1, 4'h3, 10, 4'h3, 4'h0, 1'b0, 2'b01);  // release after first press
    add(1'b0, 4'hA, 10, 4'h3, 4'hA, 1'b1, 2'b10);  // second press
    add(1'b1, 4'hA, 10, 4'h3, 4'hA, 1'b1, 2'b10);  // release
    for (int i = 0; i < 5; i++) begin               // bounce, 2-cycle pulses, SW wiggling
      add(1'b0, 4'h5, 2, 4'h3, 4'hA, 1'b1, 2'b10);
      add(1'b1, 4'hC, 2, 4'h3, 4'hA, 1'b1, 2'b10);
    end
    add(1'b1, 4'h7, 10, 4'h3, 4'hA, 1'b1, 2'b10);  // settle high after bounce
    add(1'b0, 4'h7, 10, 4'h7, 4'hA, 1'b0, 2'b01);  // wrap from FULL
    add(1'b1, 4'h7, 10, 4'h7, 4'hA, 1'b0, 2'b01);
    add(1'b0, 4'hF, 10, 4'h7, 4'hF, 1'b1, 2'b10);
    add(1'b1, 4'hF, 10, 4'h7, 4'hF, 1'b1, 2'b10);
    add(1'b0, 4'h2, 10, 4'h2, 4'hF, 1'b0, 2'b01);  // new pair, now in EXP_B
    add(1'b1, 4'h2, 10, 4'h2, 4'hF, 1'b0, 2'b01);

    // 1. Reset
    #1;
    tick(3);
    check_all("reset", 4'h0, 4'h0, 1'b0, 2'b00);
    resetn = 1'b1;
    tick(2);
    check_all("post_reset_idle", 4'h0, 4'h0, 1'b0, 2'b00);

    // 2. First press: capture exactly on edge 5 after the first low sample.
    SW = 4'h3;
    KEY_load = 1'b0;
    tick(5);   // edges 0..4
    check_all("press1_early", 4'h0, 4'h0, 1'b0, 2'b00);
    tick(1);   // edge 5
    check_all("press1_edge5", 4'h3, 4'h0, 1'b0, 2'b01);
    SW = 4'hE;
    tick(4);   // remainder of the 10-cycle hold, no second capture
    check_all("press1_held", 4'h3, 4'h0, 1'b0, 2'b01);

    // 3-5. Table-driven vectors
    for (int i = 0; i < nv; i++) begin
      KEY_load = vecs[i].key;
      SW       = vecs[i].sw;
      tick(vecs[i].ncyc);
      check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ev, vecs[i].es);
    end

    // 6. Reset mid-debounce in EXP_B, key held through reset release.
    SW = 4'h9;
    KEY_load = 1'b0;
    tick(4);   // edges 0..3: cnt reaches 2
    check_all("mid_debounce", 4'h2, 4'hF, 1'b0, 2'b01);
    resetn = 1'b0;
    tick(2);
    check_all("mid_reset", 4'h0, 4'h0, 1'b0, 2'b00);
    resetn = 1'b1;
    tick(5);   // post-reset edges 0..4
    check_all("held_reset_early", 4'h0, 4'h0, 1'b0, 2'b00);
    tick(1);   // edge 5
    check_all("held_reset_edge5", 4'h9, 4'h0, 1'b0, 2'b01);
    tick(5);
    check_all("held_reset_hold", 4'h9, 4'h0, 1'b0, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
